dma_xfer_ctrl: RTL and testbench

Transfer sequencer that drives the DMA engine's simple word-level read/write request ports (R_req/AR_ADDR/R_DATA/R_valid, W_req/AW_ADDR/W_DATA/W_done). It copies len_words 32-bit words from src_addr to dst_addr. A small prefetch FIFO decouples the read stream from the write stream. It raises a completion interrupt and sits between the DMA slave-side register file and the DMA master-side datapath.

---
 rtl/dma_ctrl_pkg.sv | 19 +
 rtl/dma_ctrl_fifo.sv | 61 ++++++
 rtl/dma_xfer_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dma_xfer_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_ctrl_pkg.sv
// Shared types and defaults for the DMA transfer sequencer.
package dma_ctrl_pkg;

   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned DEF_LEN_W      = 16;
   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned DEF_DATA_W     = 32;

   // Byte stride between consecutive 32-bit words.
   localparam int unsigned ADDR_STEP = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ABORT,
      DONE
   } state_e;

endpackage

// File: rtl/dma_ctrl_fifo.sv
// Prefetch FIFO between the read and write streams; exposes the head as it
// will look after this cycle's push/pop so the consumer can register it.
module dma_ctrl_fifo #(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 4,
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [DATA_W-1:0] head_next_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and count define which
   // entries are meaningful, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      head_next_o = mem_q[rd_ptr_q];
      if (pop_i) begin
         head_next_o = (cnt_q >= CNT_W'(2)) ? mem_q[rd_ptr_q + PTR_W'(1)] : wdata_i;
      end else if (cnt_q == '0) begin
         head_next_o = wdata_i;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Word-copy sequencer: issues reads from src into a prefetch FIFO and drains
// the FIFO into writes at dst, with abort and a sticky completion interrupt.
module dma_xfer_ctrl
   import dma_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int unsigned LEN_W      = DEF_LEN_W,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len_words,
   input  logic              irq_clr,
   output logic              busy,
   output logic              done,
   output logic              irq,
   output logic              R_req,
   output logic [ADDR_W-1:0] AR_ADDR,
   input  logic [DATA_W-1:0] R_DATA,
   input  logic              R_valid,
   output logic              W_req,
   output logic [ADDR_W-1:0] AW_ADDR,
   output logic [DATA_W-1:0] W_DATA,
   input  logic              W_done
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [LEN_W-1:0]  rd_left_q, rd_left_d, wr_left_q, wr_left_d;
   logic              r_req_q, r_req_d, w_req_q, w_req_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic              busy_q, busy_d, done_q, done_d, irq_q, irq_d;

   logic              push, pop, flush;
   logic [CNT_W-1:0]  fifo_cnt, cnt_d;
   logic [DATA_W-1:0] head_next;

   assign push = r_req_q && R_valid;
   assign pop  = w_req_q && W_done;

   dma_ctrl_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (flush),
      .wdata_i     (R_DATA),
      .count_o     (fifo_cnt),
      .head_next_o (head_next)
   );

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      rd_left_d = rd_left_q;
      wr_left_d = wr_left_q;
      flush     = 1'b0;

      if (push) begin
         rd_addr_d = rd_addr_q + ADDR_W'(ADDR_STEP);
         rd_left_d = rd_left_q - LEN_W'(1);
      end
      if (pop) begin
         wr_addr_d = wr_addr_q + ADDR_W'(ADDR_STEP);
         wr_left_d = wr_left_q - LEN_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len_words == '0) begin
                  state_d = DONE;
               end else begin
                  state_d   = RUN;
                  rd_addr_d = src_addr;
                  wr_addr_d = dst_addr;
                  rd_left_d = len_words;
                  wr_left_d = len_words;
               end
            end
         end
         RUN: begin
            // A final write completing alongside abort still counts as done.
            if (pop && wr_left_q == LEN_W'(1)) state_d = DONE;
            else if (abort)                     state_d = ABORT;
         end
         ABORT: begin
            if (!(r_req_q && !R_valid) && !(w_req_q && !W_done)) begin
               state_d = IDLE;
               flush   = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      cnt_d = fifo_cnt;
      if (flush)              cnt_d = '0;
      else if (push && !pop)  cnt_d = fifo_cnt + CNT_W'(1);
      else if (pop && !push)  cnt_d = fifo_cnt - CNT_W'(1);

      // A request holds until its completion; a new one needs RUN and room.
      r_req_d  = (r_req_q && !R_valid) ||
                 (state_d == RUN && rd_left_d != '0 && cnt_d < CNT_W'(FIFO_DEPTH));
      w_req_d  = (w_req_q && !W_done) || (state_d == RUN && cnt_d != '0);
      w_data_d = (cnt_d != '0) ? head_next : w_data_q;

      // busy covers the DONE cycle so it drops only after done has pulsed.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      if (state_d == DONE || state_q == DONE) irq_d = 1'b1;
      else if (irq_clr)                       irq_d = 1'b0;
      else                                    irq_d = irq_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         rd_left_q <= '0;
         wr_left_q <= '0;
         r_req_q   <= 1'b0;
         w_req_q   <= 1'b0;
         w_data_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         rd_left_q <= rd_left_d;
         wr_left_q <= wr_left_d;
         r_req_q   <= r_req_d;
         w_req_q   <= w_req_d;
         w_data_q  <= w_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign irq     = irq_q;
   assign R_req   = r_req_q;
   assign AR_ADDR = rd_addr_q;
   assign W_req   = w_req_q;
   assign AW_ADDR = wr_addr_q;
   assign W_DATA  = w_data_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Scoreboard bench for dma_xfer_ctrl: zero-wait responders, a handshake
// monitor popping expected reads/writes, and directed scenarios.
module tb_dma_xfer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0, irq_clr = 1'b0;
   logic [31:0] src_addr = '0, dst_addr = '0;
   logic [15:0] len_words = '0;
   logic        busy, done, irq, R_req, W_req;
   logic [31:0] AR_ADDR, AW_ADDR, W_DATA;
   logic [31:0] R_DATA = '0;
   logic        R_valid = 1'b0, W_done = 1'b0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic [31:0] exp_rd[$];
   wr_t         exp_wr[$];
   int          n_checks = 0, n_errors = 0;
   int          rd_hs = 0, done_cnt = 0;
   bit          w_en = 1'b1;

   dma_xfer_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len_words (len_words),
      .irq_clr   (irq_clr),
      .busy      (busy),
      .done      (done),
      .irq       (irq),
      .R_req     (R_req),
      .AR_ADDR   (AR_ADDR),
      .R_DATA    (R_DATA),
      .R_valid   (R_valid),
      .W_req     (W_req),
      .AW_ADDR   (AW_ADDR),
      .W_DATA    (W_DATA),
      .W_done    (W_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_A5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_xfer(input logic [31:0] s, input logic [31:0] d, input int n);
      wr_t w;
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(s + 32'(4 * i));
         w.addr = d + 32'(4 * i);
         w.data = rd_data(s + 32'(4 * i));
         exp_wr.push_back(w);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      src_addr  = s;
      dst_addr  = d;
      len_words = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         if (done) seen = 1'b1;
         else      tick();
      end
   endtask

   task automatic irq_clear(input string name);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check(name, irq, 1'b0);
   endtask

   // Zero-wait responders: complete one cycle after seeing a request.
   initial begin
      logic rq, rv, wq, wd;
      logic [31:0] ra;
      forever begin
         @(negedge clk);
         rq = R_req; rv = R_valid; ra = AR_ADDR;
         wq = W_req; wd = W_done;
         @(posedge clk);
         #1;
         R_valid = rq && !rv;
         R_DATA  = rd_data(ra);
         W_done  = w_en && wq && !wd;
      end
   end

   // Monitor: compare every completed handshake against the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         if (R_req && R_valid) begin
            rd_hs++;
            if (exp_rd.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL rd_unexpected: got read at 0x%08h expected none", AR_ADDR);
            end else begin
               check("rd_addr", AR_ADDR, exp_rd.pop_front());
            end
         end
         if (W_req && W_done) begin
            if (exp_wr.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL wr_unexpected: got write at 0x%08h expected none", AW_ADDR);
            end else begin
               e = exp_wr.pop_front();
               check("wr_addr", AW_ADDR, e.addr);
               check("wr_data", W_DATA, e.data);
            end
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish within time limit");
      $fatal(1);
   end

   initial begin
      bit  seen;
      int  d0, h0, bad;
      wr_t w;

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_irq", irq, 0);
      check("rst_rreq", R_req, 0);
      check("rst_wreq", W_req, 0);
      check("rst_araddr", AR_ADDR, 0);
      check("rst_awaddr", AW_ADDR, 0);
      check("rst_wdata", W_DATA, 0);
      rst = 1'b0;
      tick();

      // Basic 3-word copy with latency checks.
      expect_xfer(32'h1000, 32'h2000, 3);
      d0 = done_cnt;
      start_xfer(32'h1000, 32'h2000, 16'd3);
      check("t1_rreq_c1", R_req, 1);
      check("t1_araddr_c1", AR_ADDR, 32'h1000);
      check("t1_busy_c1", busy, 1);
      check("t1_wreq_c1", W_req, 0);
      tick();
      check("t1_wreq_c2", W_req, 0);
      tick();
      check("t1_wreq_c3", W_req, 1);
      check("t1_awaddr_c3", AW_ADDR, 32'h2000);
      check("t1_wdata_c3", W_DATA, rd_data(32'h1000));
      wait_done(100, seen);
      check("t1_done_seen", seen, 1);
      check("t1_irq_at_done", irq, 1);
      check("t1_busy_at_done", busy, 1);
      tick();
      check("t1_busy_after_done", busy, 0);
      check("t1_done_one_cycle", done, 0);
      tick();
      check("t1_done_count", done_cnt - d0, 1);
      check("t1_rd_left", exp_rd.size(), 0);
      check("t1_wr_left", exp_wr.size(), 0);
      irq_clear("t1_irq_clr");

      // Zero-length transfer.
      h0 = rd_hs;
      d0 = done_cnt;
      start_xfer(32'h1100, 32'h2100, 16'd0);
      check("t2_done_c1", done, 1);
      check("t2_irq_c1", irq, 1);
      check("t2_rreq_c1", R_req, 0);
      check("t2_wreq_c1", W_req, 0);
      tick();
      check("t2_done_c2", done, 0);
      check("t2_rreq_c2", R_req, 0);
      check("t2_wreq_c2", W_req, 0);
      tick();
      check("t2_done_count", done_cnt - d0, 1);
      check("t2_no_reads", rd_hs - h0, 0);
      irq_clear("t2_irq_clr");

      // Write side stalled: reads stop once the FIFO holds FIFO_DEPTH words.
      w_en = 1'b0;
      h0 = rd_hs;
      expect_xfer(32'h4000, 32'h5000, 8);
      start_xfer(32'h4000, 32'h5000, 16'd8);
      repeat (20) tick();
      check("t3_reads_while_stalled", rd_hs - h0, 4);
      check("t3_rreq_gated", R_req, 0);
      check("t3_wreq_held", W_req, 1);
      check("t3_awaddr_held", AW_ADDR, 32'h5000);
      check("t3_wdata_held", W_DATA, rd_data(32'h4000));
      w_en = 1'b1;
      wait_done(300, seen);
      check("t3_done_seen", seen, 1);
      tick();
      tick();
      check("t3_rd_left", exp_rd.size(), 0);
      check("t3_wr_left", exp_wr.size(), 0);
      irq_clear("t3_irq_clr");

      // Source address wraps through zero.
      exp_rd.push_back(32'hFFFF_FFF8);
      exp_rd.push_back(32'hFFFF_FFFC);
      exp_rd.push_back(32'h0000_0000);
      w.addr = 32'h3000; w.data = rd_data(32'hFFFF_FFF8); exp_wr.push_back(w);
      w.addr = 32'h3004; w.data = rd_data(32'hFFFF_FFFC); exp_wr.push_back(w);
      w.addr = 32'h3008; w.data = rd_data(32'h0000_0000); exp_wr.push_back(w);
      start_xfer(32'hFFFF_FFF8, 32'h3000, 16'd3);
      wait_done(100, seen);
      check("t4_done_seen", seen, 1);
      tick();
      tick();
      check("t4_rd_left", exp_rd.size(), 0);
      check("t4_wr_left", exp_wr.size(), 0);
      irq_clear("t4_irq_clr");

      // Abort while the first read is outstanding.
      exp_rd.push_back(32'h6000);
      d0 = done_cnt;
      start_xfer(32'h6000, 32'h7000, 16'd8);
      check("t5_rreq_c1", R_req, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_rreq_held", R_req, 1);
      check("t5_araddr_held", AR_ADDR, 32'h6000);
      check("t5_busy_draining", busy, 1);
      tick();
      check("t5_rreq_after", R_req, 0);
      check("t5_wreq_after", W_req, 0);
      check("t5_busy_after", busy, 0);
      bad = 0;
      repeat (8) begin
         tick();
         if (R_req || W_req || busy || done) bad++;
      end
      check("t5_quiet_cycles", bad, 0);
      check("t5_no_done", done_cnt - d0, 0);
      check("t5_no_irq", irq, 0);
      check("t5_rd_left", exp_rd.size(), 0);

      // Reset mid-RUN with two words buffered, then a clean transfer.
      w_en = 1'b0;
      h0 = rd_hs;
      expect_xfer(32'h7000, 32'h8000, 8);
      start_xfer(32'h7000, 32'h8000, 16'd8);
      for (int i = 0; i < 50 && rd_hs < h0 + 2; i++) tick();
      check("t6_two_buffered", rd_hs - h0, 2);
      rst = 1'b1;
      tick();
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_irq", irq, 0);
      check("t6_rreq", R_req, 0);
      check("t6_wreq", W_req, 0);
      check("t6_araddr", AR_ADDR, 0);
      check("t6_awaddr", AW_ADDR, 0);
      check("t6_wdata", W_DATA, 0);
      rst = 1'b0;
      exp_rd.delete();
      exp_wr.delete();
      w_en = 1'b1;
      tick();
      expect_xfer(32'h9000, 32'hA000, 2);
      start_xfer(32'h9000, 32'hA000, 16'd2);
      wait_done(100, seen);
      check("t6_done_seen", seen, 1);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("t6_irq_clr_in_done", irq, 1);
      tick();
      check("t6_rd_left", exp_rd.size(), 0);
      check("t6_wr_left", exp_wr.size(), 0);
      irq_clear("t6_irq_clr");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
